// File: rtl/external_bus_reg_bank_if.sv
// Bus-side signal bundle for external_bus_reg_bank: request/handshake from the
// master, acknowledge and read data back from the register bank.
interface external_bus_reg_bank_if #(
    parameter int ADDR_WIDTH = 19,
    parameter int DATA_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0]   address;
    logic                    bus_enable;
    logic [DATA_WIDTH/8-1:0] byte_enable;
    logic                    rw;
    logic [DATA_WIDTH-1:0]   write_data;
    logic                    acknowledge;
    logic [DATA_WIDTH-1:0]   read_data;

    modport master (
        output address,
        output bus_enable,
        output byte_enable,
        output rw,
        output write_data,
        input  acknowledge,
        input  read_data
    );

    modport slave (
        input  address,
        input  bus_enable,
        input  byte_enable,
        input  rw,
        input  write_data,
        output acknowledge,
        output read_data
    );
endinterface

// File: rtl/external_bus_reg_bank.sv
// Byte-lane writable register bank on a held-request external bus with
// programmable wait states; one transaction per request assertion.
module external_bus_reg_bank #(
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_REGS    = 4,
    parameter int ADDR_WIDTH  = 19,
    parameter int WAIT_STATES = 0
) (
    input  logic                           clk_clk,
    input  logic                           reset_reset,
    external_bus_reg_bank_if.slave         bus,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    output logic [NUM_REGS-1:0]            write_strobe,
    output logic                           busy
);
    localparam int LANES = DATA_WIDTH / 8;
    localparam int LSB   = $clog2(LANES);
    localparam int IDX_W = $clog2(NUM_REGS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);

    logic [1:0]            r_state;
    logic [3:0]            r_cnt;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_rw;
    logic [LANES-1:0]      r_be;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_ack;
    logic [NUM_REGS-1:0]   r_strobe;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

    logic [IDX_W-1:0]      w_idx;
    logic                  w_unused_addr;

    // Upper address bits are deliberately ignored so the bank aliases.
    assign w_idx         = bus.address[LSB +: IDX_W];
    assign w_unused_addr = ^bus.address;

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_rw     <= 1'b0;
            r_be     <= '0;
            r_wdata  <= '0;
            r_ack    <= 1'b0;
            r_strobe <= '0;
            r_rdata  <= '0;
            for (int unsigned k = 0; k < NUM_REGS; k++) begin
                r_regs[k] <= '0;
            end
        end else begin
            r_ack    <= 1'b0;
            r_strobe <= '0;
            case (r_state)
                S_IDLE: begin
                    if (bus.bus_enable) begin
                        r_idx   <= w_idx;
                        r_rw    <= bus.rw;
                        r_be    <= bus.byte_enable;
                        r_wdata <= bus.write_data;
                        r_cnt   <= WS_LOAD;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!bus.bus_enable) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt == '0) begin
                        r_state <= S_ACK;
                        r_ack   <= 1'b1;
                        if (r_rw) begin
                            r_rdata <= r_regs[r_idx];
                        end else begin
                            for (int unsigned i = 0; i < LANES; i++) begin
                                if (r_be[i]) begin
                                    r_regs[r_idx][i*8 +: 8] <= r_wdata[i*8 +: 8];
                                end
                            end
                            if (|r_be) begin
                                r_strobe[r_idx] <= 1'b1;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_ACK: begin
                    r_state <= bus.bus_enable ? S_HOLD : S_IDLE;
                end
                S_HOLD: begin
                    if (!bus.bus_enable) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
        assign reg_out[k*DATA_WIDTH +: DATA_WIDTH] = r_regs[k];
    end

    assign bus.acknowledge = r_ack;
    assign bus.read_data   = r_rdata;
    assign write_strobe    = r_strobe;
    assign busy            = (r_state != S_IDLE);
endmodule

// File: tb/tb_external_bus_reg_bank.sv
// Directed checks of external_bus_reg_bank: instance A with two wait states,
// instance B with none for acknowledge latency and reset-abort cases.
module tb_external_bus_reg_bank;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    external_bus_reg_bank_if #(.ADDR_WIDTH(19), .DATA_WIDTH(16)) a_if ();
    external_bus_reg_bank_if #(.ADDR_WIDTH(19), .DATA_WIDTH(16)) b_if ();

    logic [63:0] a_reg_out, b_reg_out;
    logic [3:0]  a_stb, b_stb;
    logic        a_busy, b_busy;

    external_bus_reg_bank #(
        .DATA_WIDTH(16), .NUM_REGS(4), .ADDR_WIDTH(19), .WAIT_STATES(2)
    ) dut_a (
        .clk_clk(clk), .reset_reset(rst), .bus(a_if.slave),
        .reg_out(a_reg_out), .write_strobe(a_stb), .busy(a_busy)
    );

    external_bus_reg_bank #(
        .DATA_WIDTH(16), .NUM_REGS(4), .ADDR_WIDTH(19), .WAIT_STATES(0)
    ) dut_b (
        .clk_clk(clk), .reset_reset(rst), .bus(b_if.slave),
        .reg_out(b_reg_out), .write_strobe(b_stb), .busy(b_busy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] ea [4];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] exp_a();
        return {ea[3], ea[2], ea[1], ea[0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Inputs are scrambled after the capture edge; the bank must use captured values.
    task automatic xfer_a(input logic [18:0] addr, input logic [15:0] data,
                          input logic [1:0] be, input logic rd,
                          output int lat, output logic [3:0] stb,
                          output logic [15:0] rdata, output logic ack_after);
        a_if.address     = addr;
        a_if.write_data  = data;
        a_if.byte_enable = be;
        a_if.rw          = rd;
        a_if.bus_enable  = 1'b1;
        tick();
        a_if.address     = ~addr;
        a_if.write_data  = ~data;
        a_if.byte_enable = ~be;
        a_if.rw          = ~rd;
        lat   = 0;
        stb   = '0;
        rdata = '0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (a_if.acknowledge) begin
                lat   = c;
                stb   = a_stb;
                rdata = a_if.read_data;
                break;
            end
        end
        a_if.bus_enable = 1'b0;
        tick();
        ack_after = a_if.acknowledge;
    endtask

    int          lat;
    logic [3:0]  stb;
    logic [15:0] rdv;
    logic        aa;
    int          n_ack, n_stb;
    logic        flag;

    initial begin
        #200000;
        $display("FAIL timeout: got stalled expected finish");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 4; k++) ea[k] = '0;
        rst = 1'b1;
        a_if.address = '0; a_if.bus_enable = 1'b0; a_if.byte_enable = '0;
        a_if.rw = 1'b0; a_if.write_data = '0;
        b_if.address = '0; b_if.bus_enable = 1'b0; b_if.byte_enable = '0;
        b_if.rw = 1'b0; b_if.write_data = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        check("rst_ack",   {63'd0, a_if.acknowledge}, 64'd0);
        check("rst_busy",  {63'd0, a_busy}, 64'd0);
        check("rst_regs",  a_reg_out, 64'd0);
        check("rst_rdata", {48'd0, a_if.read_data}, 64'd0);
        check("rst_stb",   {60'd0, a_stb}, 64'd0);

        // Full write to reg2
        xfer_a(19'h4, 16'hBEEF, 2'b11, 1'b0, lat, stb, rdv, aa);
        ea[2] = 16'hBEEF;
        check("w1_lat", 64'(lat), 64'd3);
        check("w1_stb", {60'd0, stb}, 64'b0100);
        check("w1_reg", {48'd0, a_reg_out[47:32]}, 64'hBEEF);
        check("w1_ack_after", {63'd0, aa}, 64'd0);
        check("w1_stb_after", {60'd0, a_stb}, 64'd0);
        check("w1_busy_after", {63'd0, a_busy}, 64'd0);

        // Byte-lane masking on reg1
        xfer_a(19'h2, 16'h1234, 2'b11, 1'b0, lat, stb, rdv, aa);
        ea[1] = 16'h1234;
        check("w2_stb", {60'd0, stb}, 64'b0010);
        xfer_a(19'h2, 16'hAB00, 2'b10, 1'b0, lat, stb, rdv, aa);
        ea[1] = 16'hAB34;
        check("w3_stb", {60'd0, stb}, 64'b0010);
        check("w3_regs", a_reg_out, exp_a());
        xfer_a(19'h2, 16'hFFFF, 2'b00, 1'b0, lat, stb, rdv, aa);
        check("w4_lat", 64'(lat), 64'd3);
        check("w4_stb", {60'd0, stb}, 64'd0);
        check("w4_regs", a_reg_out, exp_a());

        // High address bits alias onto reg0
        xfer_a(19'h40010, 16'h0F0F, 2'b11, 1'b0, lat, stb, rdv, aa);
        ea[0] = 16'h0F0F;
        check("alias_stb", {60'd0, stb}, 64'b0001);
        check("alias_regs", a_reg_out, exp_a());

        // Read back, then a write must not disturb read_data
        xfer_a(19'h6, 16'h5A5A, 2'b11, 1'b0, lat, stb, rdv, aa);
        ea[3] = 16'h5A5A;
        xfer_a(19'h6, 16'h0000, 2'b00, 1'b1, lat, stb, rdv, aa);
        check("r1_lat", 64'(lat), 64'd3);
        check("r1_data", {48'd0, rdv}, 64'h5A5A);
        check("r1_stb", {60'd0, stb}, 64'd0);
        xfer_a(19'h0, 16'h1111, 2'b11, 1'b0, lat, stb, rdv, aa);
        ea[0] = 16'h1111;
        check("r1_hold", {48'd0, a_if.read_data}, 64'h5A5A);
        check("r1_regs", a_reg_out, exp_a());
        xfer_a(19'h3, 16'h0000, 2'b11, 1'b1, lat, stb, rdv, aa);
        check("r2_data", {48'd0, rdv}, 64'hAB34);
        check("r2_regs", a_reg_out, exp_a());

        // Abort one cycle after capture
        a_if.address = 19'h0; a_if.write_data = 16'hDEAD; a_if.byte_enable = 2'b11;
        a_if.rw = 1'b0; a_if.bus_enable = 1'b1;
        tick();
        a_if.bus_enable = 1'b0;
        tick();
        check("abort_busy", {63'd0, a_busy}, 64'd0);
        flag = 1'b0;
        repeat (5) begin
            if (a_if.acknowledge || (a_stb != 4'd0)) flag = 1'b1;
            tick();
        end
        check("abort_no_ack", {63'd0, flag}, 64'd0);
        check("abort_regs", a_reg_out, exp_a());

        // Request held for 10 cycles yields one transaction
        a_if.address = 19'h0; a_if.write_data = 16'h7777; a_if.byte_enable = 2'b01;
        a_if.rw = 1'b0; a_if.bus_enable = 1'b1;
        tick();
        n_ack = 0; n_stb = 0; flag = 1'b1;
        repeat (10) begin
            tick();
            if (a_if.acknowledge) n_ack++;
            if (a_stb != 4'd0) n_stb++;
            if (!a_busy) flag = 1'b0;
        end
        ea[0] = 16'h1177;
        check("hold_acks", 64'(n_ack), 64'd1);
        check("hold_stbs", 64'(n_stb), 64'd1);
        check("hold_busy", {63'd0, flag}, 64'd1);
        a_if.bus_enable = 1'b0;
        tick();
        check("hold_release", {63'd0, a_busy}, 64'd0);
        check("hold_regs", a_reg_out, exp_a());

        // Reset while waiting
        a_if.address = 19'h4; a_if.write_data = 16'h0000; a_if.byte_enable = 2'b11;
        a_if.rw = 1'b0; a_if.bus_enable = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) ea[k] = '0;
        check("rstw_busy",  {63'd0, a_busy}, 64'd0);
        check("rstw_ack",   {63'd0, a_if.acknowledge}, 64'd0);
        check("rstw_regs",  a_reg_out, 64'd0);
        check("rstw_rdata", {48'd0, a_if.read_data}, 64'd0);
        a_if.bus_enable = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        check("rstw_post_regs", a_reg_out, 64'd0);
        check("rstw_post_busy", {63'd0, a_busy}, 64'd0);
        xfer_a(19'h0, 16'h2222, 2'b11, 1'b0, lat, stb, rdv, aa);
        ea[0] = 16'h2222;
        check("rstw_new_lat", 64'(lat), 64'd3);
        check("rstw_new_regs", a_reg_out, exp_a());

        // Zero wait states: acknowledge on the edge after capture
        b_if.address = 19'h2; b_if.write_data = 16'hCAFE; b_if.byte_enable = 2'b11;
        b_if.rw = 1'b0; b_if.bus_enable = 1'b1;
        tick();
        check("b_e0_ack", {63'd0, b_if.acknowledge}, 64'd0);
        tick();
        check("b_ack", {63'd0, b_if.acknowledge}, 64'd1);
        check("b_stb", {60'd0, b_stb}, 64'b0010);
        check("b_reg", b_reg_out, 64'h0000_0000_CAFE_0000);
        b_if.bus_enable = 1'b0;
        tick();
        check("b_ack_after", {63'd0, b_if.acknowledge}, 64'd0);

        // Reset while acknowledge is high
        b_if.address = 19'h0; b_if.write_data = 16'h9999;
        b_if.bus_enable = 1'b1;
        tick();
        tick();
        check("b2_ack", {63'd0, b_if.acknowledge}, 64'd1);
        rst = 1'b1;
        #1;
        check("b2_rst_ack",  {63'd0, b_if.acknowledge}, 64'd0);
        check("b2_rst_stb",  {60'd0, b_stb}, 64'd0);
        check("b2_rst_busy", {63'd0, b_busy}, 64'd0);
        check("b2_rst_regs", b_reg_out, 64'd0);
        b_if.bus_enable = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // Reset between capture and the would-be acknowledge edge
        b_if.address = 19'h4; b_if.write_data = 16'h4444;
        b_if.bus_enable = 1'b1;
        tick();
        rst = 1'b1;
        #1;
        check("b3_rst_busy", {63'd0, b_busy}, 64'd0);
        tick();
        b_if.bus_enable = 1'b0;
        rst = 1'b0;
        tick();
        tick();
        check("b3_regs", b_reg_out, 64'd0);
        check("b3_ack",  {63'd0, b_if.acknowledge}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/external_bus_reg_bank.md
EXTERNAL_BUS_REG_BANK -- requirements
Module: external_bus_reg_bank

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning bus and register width in bits; legal values are multiples of 8 from 8 to 64.
REQ-002 SHALL have parameter NUM_REGS, default 4, meaning register count; legal values are powers of 2 from 2 to 64.
REQ-003 SHALL have parameter ADDR_WIDTH, default 19, meaning byte-address width.
REQ-004 SHALL have parameter WAIT_STATES, default 0, meaning extra cycles inserted before acknowledge; legal range 0..15.
REQ-005 SHALL have port clk_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset_reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port address, input, ADDR_WIDTH bits: byte address.
REQ-008 SHALL have port bus_enable, input, 1 bit: transaction request, held high by the master until acknowledged.
REQ-009 SHALL have port byte_enable, input, DATA_WIDTH/8 bits: write lane mask, where bit i selects byte lane i.
REQ-010 SHALL have port rw, input, 1 bit: 1 = read, 0 = write.
REQ-011 SHALL have port write_data, input, DATA_WIDTH bits: write data, lane-aligned.
REQ-012 SHALL have port acknowledge, output, 1 bit: registered one-cycle completion pulse.
REQ-013 SHALL have port read_data, output, DATA_WIDTH bits: registered read data.
REQ-014 SHALL have port reg_out, output, NUM_REGS*DATA_WIDTH bits: all registers flattened, register k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-015 SHALL have port write_strobe, output, NUM_REGS bits: one-cycle pulse per register, asserted on update.
REQ-016 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-017 SHALL form the register index as address[LSB +: log2(NUM_REGS)], with LSB = log2(DATA_WIDTH/8); higher address bits are ignored, so the register set aliases across the address space.
REQ-018 SHALL implement FSM states IDLE, WAIT, ACK and HOLD.
REQ-019 In IDLE, with bus_enable=1 at an edge, SHALL capture address index, rw, byte_enable and write_data, load the wait counter with WAIT_STATES, and go to WAIT.
REQ-020 In WAIT, if bus_enable=0 at an edge, SHALL abort to IDLE with no write, no acknowledge and no strobe.
REQ-021 In WAIT, with bus_enable=1 and counter=0, SHALL go to ACK; otherwise SHALL decrement the counter and stay in WAIT.
REQ-022 acknowledge SHALL rise at edge E0+1+WAIT_STATES, where E0 is the capture edge, and SHALL stay high for exactly one cycle (the ACK state).
REQ-023 On a write, at the edge entering ACK, SHALL update each byte lane i of the indexed register with write_data lane i where byte_enable[i]=1; lanes with byte_enable[i]=0 are unchanged.
REQ-024 On a write, SHALL pulse write_strobe[index] for that same cycle only if at least one byte_enable bit is 1.
REQ-025 A write with byte_enable all zero SHALL still be acknowledged, SHALL change no register and SHALL raise no strobe.
REQ-026 On a read, at the edge entering ACK, SHALL load read_data with the indexed register; read_data holds until the next read's ACK edge, and a write SHALL leave read_data unchanged.
REQ-027 From ACK, SHALL go to HOLD if bus_enable=1, else to IDLE.
REQ-028 HOLD SHALL stay until bus_enable=0, then go to IDLE, so a request held high produces exactly one transaction.
REQ-029 Captured values SHALL be used for the whole transaction; input changes after E0 are ignored.
REQ-030 Registers SHALL be modified only through the ACK-entry write path.

Reset
REQ-031 Asserting reset_reset SHALL immediately force the FSM to IDLE and clear the wait counter, all registers, reg_out, read_data, acknowledge, write_strobe and busy to 0, including mid-transaction.
REQ-032 After reset deasserts, the first edge with bus_enable=1 SHALL start a new transaction; no partial write from the interrupted transaction SHALL occur.

Verification (DATA_WIDTH=16, NUM_REGS=4, WAIT_STATES=2 unless noted)
REQ-033 Write 0xBEEF to address 0x4 with byte_enable=11 -> acknowledge high exactly 3 cycles after E0 for 1 cycle; reg_out[47:32]=0xBEEF; write_strobe=0100 pulsed in the same cycle.
REQ-034 reg1=0x1234, then write 0xAB00 to address 0x2 with byte_enable=10 -> reg1=0xAB34; then byte_enable=00 -> acknowledge occurs, reg1 stays 0xAB34, no strobe.
REQ-035 Write 0x5A5A to reg3, then read address 0x6 -> read_data=0x5A5A during acknowledge and still 0x5A5A after a subsequent write to reg0.
REQ-036 Drop bus_enable one cycle after E0 -> no acknowledge, reg_out unchanged, busy low on the next cycle.
REQ-037 Hold bus_enable high for 10 cycles on a write -> one acknowledge, one strobe; busy stays high until bus_enable falls.
REQ-038 Assert reset_reset in WAIT, and separately with WAIT_STATES=0 (acknowledge at E0+1) -> all outputs 0 asynchronously, FSM in IDLE, no register write.
